// File: rtl/imem_pkg.sv
// Shared types for the loadable instruction memory: load FSM state encoding
// and the parity helper used when IMEM_PARITY_EN is defined.
package imem_pkg;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_e;

  localparam int PAR_MAX_W = 256;

  // Reduction XOR; callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic imem_parity(input logic [PAR_MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/imem_load_fsm.sv
// Program-load sequencer: accepts a (base, len) request and walks a wrapping
// write pointer across the array, one word per load_valid & load_ready beat.
module imem_load_fsm
  import imem_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_start_i,
  input  logic [AW-1:0] load_base_i,
  input  logic [AW:0]   load_len_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          load_done_o,
  output logic          fetch_busy_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  load_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_clamped;

  assign len_clamped = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LD_IDLE: begin
        if (load_start_i) begin
          if (len_clamped == '0) begin
            state_d = LD_DONE;
          end else begin
            state_d = LD_LOAD;
            ptr_d   = load_base_i;
            cnt_d   = len_clamped;
          end
        end
      end
      LD_LOAD: begin
        if (load_valid_i) begin
          ptr_d = (ptr_q == LAST_IX) ? '0 : ptr_q + AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
          if (cnt_q == (AW+1)'(1)) begin
            state_d = LD_DONE;
          end
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer and count are only meaningful in LOAD, so they carry no reset.
  always_ff @(posedge clk_i) begin
    ptr_q <= ptr_d;
    cnt_q <= cnt_d;
  end

  assign load_ready_o = (state_q == LD_LOAD);
  assign load_done_o  = (state_q == LD_DONE);
  assign fetch_busy_o = (state_q != LD_IDLE);
  assign we_o         = (state_q == LD_LOAD) && load_valid_i;
  assign waddr_o      = ptr_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a registered 1-cycle fetch port, fault detection and
// a handshaked reload port. Define IMEM_PARITY_EN to store and check even parity per word.
module imem_loadable
  import imem_pkg::*;
#(
  parameter  int              WIDTH     = 32,
  parameter  int              DEPTH     = 16,
  parameter  int              PC_W      = 32,
  parameter  int              ADDR_LSB  = 2,
  parameter  logic [WIDTH-1:0] NOP_WORD = '0,
  parameter  string           INIT_FILE = "",
  localparam int              AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             fetch_busy,
  output logic             ir_valid,
  output logic [WIDTH-1:0] ir,
  output logic             ir_fault,
  input  logic             load_start,
  input  logic [AW-1:0]    load_base,
  input  logic [AW:0]      load_len,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             load_done
`ifdef IMEM_PARITY_EN
  ,
  output logic             ir_parity_err
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  localparam logic [PC_W-1:0] ALIGN_MASK = (PC_W'(1) << ADDR_LSB) - PC_W'(1);
  localparam logic [PC_W-1:0] DEPTH_PC   = PC_W'(DEPTH);
  localparam logic [AW:0]     DEPTH_L    = (AW+1)'(DEPTH);

  logic [MEM_W-1:0] mem_q [DEPTH];

  logic             we;
  logic [AW-1:0]    waddr;
  logic [MEM_W-1:0] wdata;

  imem_load_fsm #(
    .DEPTH (DEPTH)
  ) u_load_fsm (
    .clk_i        (clk),
    .rst_ni       (reset),
    .load_start_i (load_start),
    .load_base_i  (load_base),
    .load_len_i   (load_len),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_done_o  (load_done),
    .fetch_busy_o (fetch_busy),
    .we_o         (we),
    .waddr_o      (waddr)
  );

`ifdef IMEM_PARITY_EN
  assign wdata = {imem_parity(PAR_MAX_W'(load_data)), load_data};
`else
  assign wdata = load_data;
`endif

  // A base index beyond DEPTH (non power-of-two depths) must not write outside the array.
  always_ff @(posedge clk) begin
    if (we && ((AW+1)'(waddr) < DEPTH_L)) begin
      mem_q[waddr] <= wdata;
    end
  end

  logic             misaligned, out_of_range, fault, accept;
  logic [AW-1:0]    fidx;
  logic [MEM_W-1:0] rd_word;

  assign misaligned   = |(fetch_pc & ALIGN_MASK);
  assign out_of_range = (fetch_pc >> ADDR_LSB) >= DEPTH_PC;
  assign fault        = misaligned || out_of_range;
  assign accept       = fetch_req && !fetch_busy;
  assign fidx         = fetch_pc[ADDR_LSB +: AW];
  assign rd_word      = mem_q[fidx];

  logic             ir_valid_q, ir_valid_d;
  logic             ir_fault_q, ir_fault_d;
  logic [WIDTH-1:0] ir_q, ir_d;
`ifdef IMEM_PARITY_EN
  logic             perr_q, perr_d;
`endif

  always_comb begin
    ir_valid_d = accept;
    ir_fault_d = ir_fault_q;
    ir_d       = ir_q;
`ifdef IMEM_PARITY_EN
    perr_d     = perr_q;
`endif
    if (accept) begin
      ir_fault_d = fault;
      ir_d       = fault ? NOP_WORD : rd_word[WIDTH-1:0];
`ifdef IMEM_PARITY_EN
      perr_d     = !fault && imem_parity(PAR_MAX_W'(rd_word));
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_valid_q <= 1'b0;
      ir_fault_q <= 1'b0;
      ir_q       <= NOP_WORD;
`ifdef IMEM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      ir_valid_q <= ir_valid_d;
      ir_fault_q <= ir_fault_d;
      ir_q       <= ir_d;
`ifdef IMEM_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign ir_valid = ir_valid_q;
  assign ir_fault = ir_fault_q;
  assign ir       = ir_q;
`ifdef IMEM_PARITY_EN
  assign ir_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: directed vector table, hand-written reset/parity
// sequences and a randomized phase checked against a behavioural model.
module tb_imem_loadable;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] A0 = 32'hA0A0_0001, A1 = 32'hA1A1_0002, A2 = 32'hA2A2_0003, A3 = 32'hA3A3_0004;
  localparam logic [31:0] B0 = 32'hB0B0_1111, B1 = 32'hB1B1_2222, C0 = 32'hC0C0_3333;
  localparam logic [31:0] D0 = 32'hD0D0_4444, D1 = 32'hD1D1_5555;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_busy, ir_valid, ir_fault;
  logic [31:0] ir;
  logic        load_start;
  logic [3:0]  load_base;
  logic [4:0]  load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_done;
`ifdef IMEM_PARITY_EN
  logic        ir_parity_err;
`endif

  imem_loadable #(
    .WIDTH(32), .DEPTH(DEPTH), .PC_W(32), .ADDR_LSB(2), .NOP_WORD(NOP), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_busy(fetch_busy), .ir_valid(ir_valid), .ir(ir), .ir_fault(ir_fault),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done)
`ifdef IMEM_PARITY_EN
    , .ir_parity_err(ir_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: memory image plus "how many words are still owed" view of a load.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_bad [DEPTH];
  bit          m_loading, m_done, m_valid, m_fault, m_perr, m_ir_known;
  int          m_left, m_ptr;
  logic [31:0] m_ir;

  task automatic model_reset();
    m_loading = 0; m_done = 0; m_valid = 0; m_fault = 0; m_perr = 0;
    m_ir = NOP; m_ir_known = 1;
  endtask

  task automatic model_step(input bit req, input logic [31:0] pc, input bit st,
                            input int base, input int len, input bit lv, input logic [31:0] ld);
    bit idle;
    int idx;
    idle    = !m_loading && !m_done;
    m_valid = req && idle;
    if (m_valid) begin
      m_fault = (pc % 4 != 0) || (pc / 4 >= DEPTH);
      if (m_fault) begin
        m_ir = NOP; m_ir_known = 1; m_perr = 0;
      end else begin
        idx = int'(pc / 4);
        m_ir = m_mem[idx]; m_ir_known = m_known[idx]; m_perr = m_bad[idx];
      end
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_loading) begin
      if (lv) begin
        m_mem[m_ptr] = ld; m_known[m_ptr] = 1; m_bad[m_ptr] = 0;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_left--;
        if (m_left == 0) begin
          m_loading = 0; m_done = 1;
        end
      end
    end else if (st) begin
      if (len == 0) m_done = 1;
      else begin
        m_loading = 1; m_left = (len > DEPTH) ? DEPTH : len; m_ptr = base;
      end
    end
  endtask

  task automatic apply(input bit req, input logic [31:0] pc, input bit st, input int base,
                       input int len, input bit lv, input logic [31:0] ld);
    fetch_req = req; fetch_pc = pc; load_start = st; load_base = 4'(base);
    load_len = 5'(len); load_valid = lv; load_data = ld;
    @(posedge clk);
    #1;
    model_step(req, pc, st, base, len, lv, ld);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".busy"},  32'(fetch_busy), 32'(m_loading || m_done));
    chk({tag, ".ready"}, 32'(load_ready), 32'(m_loading));
    chk({tag, ".done"},  32'(load_done),  32'(m_done));
    chk({tag, ".valid"}, 32'(ir_valid),   32'(m_valid));
    if (m_valid) chk({tag, ".fault"}, 32'(ir_fault), 32'(m_fault));
    if (m_ir_known) chk({tag, ".ir"}, ir, m_ir);
`ifdef IMEM_PARITY_EN
    if (m_valid) chk({tag, ".perr"}, 32'(ir_parity_err), 32'(m_perr));
`endif
  endtask

  typedef struct {
    bit          req;
    logic [31:0] pc;
    bit          st;
    int          base;
    int          len;
    bit          lv;
    logic [31:0] ld;
    bit          e_valid, e_fault;
    logic [31:0] e_ir;
    bit          e_busy, e_ready, e_done;
  } vec_t;

  function automatic vec_t mk(bit req, logic [31:0] pc, bit st, int base, int len, bit lv,
                              logic [31:0] ld, bit ev, bit ef, logic [31:0] eir,
                              bit eb, bit er, bit ed);
    vec_t v;
    v.req = req; v.pc = pc; v.st = st; v.base = base; v.len = len; v.lv = lv; v.ld = ld;
    v.e_valid = ev; v.e_fault = ef; v.e_ir = eir; v.e_busy = eb; v.e_ready = er; v.e_done = ed;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: total=%0d", total);
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] pc, rdata;
    int sel;

    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 0; m_bad[i] = 0; m_mem[i] = '0;
    end
    model_reset();
    fetch_req = 0; fetch_pc = 0; load_start = 0; load_base = 0;
    load_len = 0; load_valid = 0; load_data = 0;

    reset = 1'b1;
    #1 reset = 1'b0;
    #3;
    chk("rst.ir", ir, NOP);
    chk("rst.valid", 32'(ir_valid), 32'd0);
    chk("rst.busy", 32'(fetch_busy), 32'd0);
    chk("rst.ready", 32'(load_ready), 32'd0);
    chk("rst.done", 32'(load_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.ir", ir, NOP);
    chk("rel.valid", 32'(ir_valid), 32'd0);
    chk("rel.busy", 32'(fetch_busy), 32'd0);

    // Load 4 words, fetch, faults, fetch-while-busy, zero-length load, wrapped load.
    tbl.push_back(mk(0, 0,     1, 0, 4, 0, 0,  0, 0, NOP, 1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, A0, 0, 0, NOP, 1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, A1, 0, 0, NOP, 1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, A2, 0, 0, NOP, 1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, A3, 0, 0, NOP, 1, 0, 1));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0,  0, 0, NOP, 0, 0, 0));
    tbl.push_back(mk(1, 32'h8, 0, 0, 0, 0, 0,  1, 0, A2,  0, 0, 0));
    tbl.push_back(mk(1, 32'h6, 0, 0, 0, 0, 0,  1, 1, NOP, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40,0, 0, 0, 0, 0,  1, 1, NOP, 0, 0, 0));
    tbl.push_back(mk(1, 32'h0, 1, 8, 1, 0, 0,  1, 0, A0,  1, 1, 0));
    tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0,  0, 0, A0,  1, 1, 0));
    tbl.push_back(mk(1, 32'h4, 0, 0, 0, 1, C0, 0, 0, A0,  1, 0, 1));
    tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0,  0, 0, A0,  0, 0, 0));
    tbl.push_back(mk(1, 32'h4, 0, 0, 0, 0, 0,  1, 0, A1,  0, 0, 0));
    tbl.push_back(mk(1, 32'h20,0, 0, 0, 0, 0,  1, 0, C0,  0, 0, 0));
    tbl.push_back(mk(0, 0,     1, 3, 0, 0, 0,  0, 0, C0,  1, 0, 1));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0,  0, 0, C0,  0, 0, 0));
    tbl.push_back(mk(0, 0,     1, 15,2, 0, 0,  0, 0, C0,  1, 1, 0));
    tbl.push_back(mk(0, 0,     1, 3, 5, 0, 0,  0, 0, C0,  1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, B0, 0, 0, C0,  1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0,  0, 0, C0,  1, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 1, B1, 0, 0, C0,  1, 0, 1));
    tbl.push_back(mk(0, 0,     0, 0, 0, 0, 0,  0, 0, C0,  0, 0, 0));
    tbl.push_back(mk(1, 32'h0, 0, 0, 0, 0, 0,  1, 0, B1,  0, 0, 0));
    tbl.push_back(mk(1, 32'h3C,0, 0, 0, 0, 0,  1, 0, B0,  0, 0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      apply(v.req, v.pc, v.st, v.base, v.len, v.lv, v.ld);
      chk($sformatf("row%0d.valid", i), 32'(ir_valid),   32'(v.e_valid));
      chk($sformatf("row%0d.ir", i),    ir,              v.e_ir);
      chk($sformatf("row%0d.busy", i),  32'(fetch_busy), 32'(v.e_busy));
      chk($sformatf("row%0d.ready", i), 32'(load_ready), 32'(v.e_ready));
      chk($sformatf("row%0d.done", i),  32'(load_done),  32'(v.e_done));
      if (v.e_valid) chk($sformatf("row%0d.fault", i), 32'(ir_fault), 32'(v.e_fault));
    end

    // Reset in the middle of a 4-word load after two beats.
    apply(0, 0, 1, 0, 4, 0, 0);
    apply(0, 0, 0, 0, 0, 1, D0);
    apply(0, 0, 0, 0, 0, 1, D1);
    fetch_req = 0; load_start = 0; load_valid = 0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("midrst.busy", 32'(fetch_busy), 32'd0);
    chk("midrst.ready", 32'(load_ready), 32'd0);
    chk("midrst.done", 32'(load_done), 32'd0);
    chk("midrst.ir", ir, NOP);
    #1 reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("midrst.nodone", 32'(load_done), 32'd0);
    apply(1, 32'h0, 0, 0, 0, 0, 0);
    chk("midrst.w0", ir, D0);
    apply(1, 32'h4, 0, 0, 0, 0, 0);
    chk("midrst.w1", ir, D1);
    apply(1, 32'h8, 0, 0, 0, 0, 0);
    chk("midrst.w2", ir, A2);
    apply(1, 32'hC, 0, 0, 0, 0, 0);
    chk("midrst.w3", ir, A3);
    chk("midrst.valid", 32'(ir_valid), 32'd1);

`ifdef IMEM_PARITY_EN
    dut.mem_q[1] = dut.mem_q[1] ^ 33'h8;
    m_mem[1] = m_mem[1] ^ 32'h8;
    m_bad[1] = 1;
    apply(1, 32'h4, 0, 0, 0, 0, 0);
    chk("par.valid", 32'(ir_valid), 32'd1);
    chk("par.err", 32'(ir_parity_err), 32'd1);
    chk("par.ir", ir, D1 ^ 32'h8);
    apply(1, 32'h8, 0, 0, 0, 0, 0);
    chk("par.clean", 32'(ir_parity_err), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      pc  = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (sel == 7) pc = pc + 32'($urandom_range(1, 3));
      else if (sel == 8) pc = pc + 32'h40;
      else if (sel == 9) pc = $urandom;
      rdata = $urandom;
      apply($urandom_range(0, 1) == 1, pc, $urandom_range(0, 9) == 0,
            $urandom_range(0, DEPTH - 1), $urandom_range(0, 20),
            $urandom_range(0, 9) < 6, rdata);
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
